serial_pattern_tx: RTL and testbench

- Transmit-side counterpart of the team's serial sequence detectors (e.g. the 1011 Mealy detector).
- Loads a parallel word and emits it one bit per debounced step press, LSB-first by default, with a one-cycle valid strobe per bit.
- Sits between the switch/key front end and any serial consumer; gives the detector lab a self-driven stimulus source.
- Fully synchronous; key inputs are already-debounced levels and are edge-detected internally.

---
 rtl/serial_pkg.sv | 15 +
 rtl/edge_pulse.sv | 22 ++
 rtl/serial_pattern_tx.sv | 105 ++++++++++
 tb/tb_serial_pattern_tx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared constants for the serial pattern transmitter: FSM state encoding
// and the roles of the two key inputs.
package serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    localparam int KEY_STEP = 0;
    localparam int KEY_LOAD = 1;
    localparam int NUM_KEYS = 2;

endpackage : serial_pkg

// File: rtl/edge_pulse.sv
// One-bit rising-edge detector on an already-debounced level.
// History resets high so a key held through reset is not treated as a press.
module edge_pulse (
    input  logic clk,
    input  logic set,
    input  logic lvl_i,
    output logic pulse_o
);

    logic hist_q;

    always_ff @(posedge clk) begin
        if (set) begin
            hist_q <= 1'b1;
        end else begin
            hist_q <= lvl_i;
        end
    end

    assign pulse_o = lvl_i & ~hist_q;

endmodule : edge_pulse

// File: rtl/serial_pattern_tx.sv
// Loads a parallel word on a load-key press and emits one bit per step-key
// press, with a one-cycle valid strobe per emitted bit.
module serial_pattern_tx
    import serial_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 0
) (
    input  logic                     clk,
    input  logic                     set,
    input  logic [WIDTH-1:0]         data,
    input  logic [1:0]               key,
    output logic                     sout,
    output logic                     sout_valid,
    output logic [$clog2(WIDTH):0]   bit_idx,
    output logic                     work,
    output logic                     done
);

    localparam int                IDX_W    = $clog2(WIDTH) + 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);

    logic [NUM_KEYS-1:0] key_p;
    logic                ld_p;
    logic                st_p;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key_edge
            edge_pulse u_edge (
                .clk     (clk),
                .set     (set),
                .lvl_i   (key[gi]),
                .pulse_o (key_p[gi])
            );
        end
    endgenerate

    assign ld_p = key_p[KEY_LOAD];
    assign st_p = key_p[KEY_STEP];

    state_e             state_q;
    logic [WIDTH-1:0]   shreg_q;
    logic [WIDTH-1:0]   shreg_d;
    logic               emit_bit;
    logic               sout_q;
    logic               sout_valid_q;
    logic [IDX_W-1:0]   bit_idx_q;
    logic               work_q;
    logic               done_q;

    // The emitted end is always the end the register shifts toward, so the
    // next bit to send is always sitting at that end.
    always_comb begin
        emit_bit = 1'b0;
        shreg_d  = shreg_q;
        if (MSB_FIRST != 0) begin
            emit_bit = shreg_q[WIDTH-1];
            shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin
            emit_bit = shreg_q[0];
            shreg_d  = {1'b0, shreg_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (set) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            bit_idx_q    <= '0;
            work_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            sout_valid_q <= 1'b0;
            // Load wins over a coincident step; that step is simply dropped.
            if (ld_p) begin
                state_q   <= ST_SHIFT;
                shreg_q   <= data;
                bit_idx_q <= '0;
                work_q    <= 1'b1;
                done_q    <= 1'b0;
            end else if (st_p && (state_q == ST_SHIFT)) begin
                sout_q       <= emit_bit;
                sout_valid_q <= 1'b1;
                shreg_q      <= shreg_d;
                bit_idx_q    <= bit_idx_q + IDX_ONE;
                if (bit_idx_q == LAST_IDX) begin
                    state_q <= ST_DONE;
                    work_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
            end
        end
    end

    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign bit_idx    = bit_idx_q;
    assign work       = work_q;
    assign done       = done_q;

endmodule : serial_pattern_tx

// File: tb/tb_serial_pattern_tx.sv
// Scoreboard bench for serial_pattern_tx: an LSB-first and an MSB-first
// instance share stimulus and are checked against a word/count model.
module tb_serial_pattern_tx;

    localparam int W = 8;

    typedef struct packed {
        logic       b;
        logic [3:0] idx;
        logic       dn;
        logic       wk;
    } exp_t;

    typedef enum int {M_IDLE, M_ACTIVE, M_FINISHED} mstate_e;

    logic         clk;
    logic         set;
    logic [W-1:0] data;
    logic [1:0]   key;

    logic         sout_l, valid_l, work_l, done_l;
    logic [3:0]   idx_l;
    logic         sout_m, valid_m, work_m, done_m;
    logic [3:0]   idx_m;

    int errors = 0;
    int checks = 0;

    exp_t q_lsb[$];
    exp_t q_msb[$];

    logic [W-1:0] m_word [2];
    int           m_cnt  [2];
    mstate_e      m_st   [2];
    logic         m_sout [2];
    logic [1:0]   prev_key;

    serial_pattern_tx #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .set(set), .data(data), .key(key),
        .sout(sout_l), .sout_valid(valid_l), .bit_idx(idx_l),
        .work(work_l), .done(done_l)
    );

    serial_pattern_tx #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .set(set), .data(data), .key(key),
        .sout(sout_m), .sout_valid(valid_m), .bit_idx(idx_m),
        .work(work_m), .done(done_m)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: every valid strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (valid_l === 1'b1) begin
            checks++;
            if (q_lsb.size() == 0) begin
                errors++;
                $display("FAIL lsb_unexpected_valid sout=%0d bit_idx=%0d (no bit expected)", sout_l, idx_l);
            end else begin
                e = q_lsb.pop_front();
                if ({sout_l, idx_l, done_l, work_l} !== e) begin
                    errors++;
                    $display("FAIL lsb_bit got sout=%0d idx=%0d done=%0d work=%0d want sout=%0d idx=%0d done=%0d work=%0d",
                             sout_l, idx_l, done_l, work_l, e.b, e.idx, e.dn, e.wk);
                end
            end
        end
        if (valid_m === 1'b1) begin
            checks++;
            if (q_msb.size() == 0) begin
                errors++;
                $display("FAIL msb_unexpected_valid sout=%0d bit_idx=%0d (no bit expected)", sout_m, idx_m);
            end else begin
                e = q_msb.pop_front();
                if ({sout_m, idx_m, done_m, work_m} !== e) begin
                    errors++;
                    $display("FAIL msb_bit got sout=%0d idx=%0d done=%0d work=%0d want sout=%0d idx=%0d done=%0d work=%0d",
                             sout_m, idx_m, done_m, work_m, e.b, e.idx, e.dn, e.wk);
                end
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_word[i] = '0;
            m_cnt[i]  = 0;
            m_st[i]   = M_IDLE;
            m_sout[i] = 1'b0;
        end
        prev_key = 2'b11;
    endtask

    // Apply one cycle of key/data levels and advance the model accordingly.
    task automatic drive(input logic [1:0] k, input logic [W-1:0] d);
        logic ld, st, b;
        exp_t e;
        ld = k[1] & ~prev_key[1];
        st = k[0] & ~prev_key[0];
        prev_key = k;
        key  = k;
        data = d;
        for (int i = 0; i < 2; i++) begin
            if (ld) begin
                m_word[i] = d;
                m_cnt[i]  = 0;
                m_st[i]   = M_ACTIVE;
            end else if (st && m_st[i] == M_ACTIVE) begin
                b = (i == 1) ? m_word[i][W-1-m_cnt[i]] : m_word[i][m_cnt[i]];
                m_cnt[i]++;
                if (m_cnt[i] == W) m_st[i] = M_FINISHED;
                m_sout[i] = b;
                e.b   = b;
                e.idx = 4'(m_cnt[i]);
                e.dn  = (m_st[i] == M_FINISHED);
                e.wk  = (m_st[i] == M_ACTIVE);
                if (i == 0) q_lsb.push_back(e);
                else        q_msb.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [1:0] k);
        set = 1'b1;
        key = k;
        model_clear();
        @(negedge clk);
        set = 1'b0;
    endtask

    task automatic check_levels(input string tag);
        logic [6:0] got, want;
        for (int i = 0; i < 2; i++) begin
            want = {m_sout[i], 4'(m_cnt[i]), logic'(m_st[i] == M_ACTIVE), logic'(m_st[i] == M_FINISHED)};
            got  = (i == 0) ? {sout_l, idx_l, work_l, done_l} : {sout_m, idx_m, work_m, done_m};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s_%s got sout/idx/work/done=%b want %b", tag, (i == 0) ? "lsb" : "msb", got, want);
            end
        end
    endtask

    task automatic press_step(input logic [W-1:0] d);
        drive(2'b01, d);
        drive(2'b00, d);
    endtask

    initial begin
        set  = 1'b1;
        key  = 2'b11;
        data = '0;
        model_clear();

        // Keys held through reset must not produce edges.
        do_reset(2'b11);
        check_levels("reset_state");
        for (int c = 0; c < 5; c++) drive(2'b11, 8'hA5);
        check_levels("held_keys");
        drive(2'b00, 8'h00);

        // Full frame of 8'h0D, then two extra steps after completion.
        drive(2'b10, 8'h0D);
        drive(2'b00, 8'h55);
        check_levels("after_load");
        for (int s = 0; s < 8; s++) press_step(8'h00);
        check_levels("frame_done");
        press_step(8'h00);
        press_step(8'h00);
        check_levels("steps_after_done");

        // Partial frame of 8'hB0: MSB instance sends 1,0,1,1.
        drive(2'b10, 8'hB0);
        drive(2'b00, 8'h00);
        for (int s = 0; s < 4; s++) press_step(8'h00);
        check_levels("partial_b0");

        // Load and step rise together mid-frame: step is dropped.
        drive(2'b11, 8'hFF);
        check_levels("load_step_same");
        drive(2'b00, 8'h00);
        press_step(8'h00);
        check_levels("after_restart");

        // Reset three bits into a frame aborts it; later steps are ignored.
        drive(2'b10, 8'h0D);
        drive(2'b00, 8'h00);
        for (int s = 0; s < 3; s++) press_step(8'h00);
        check_levels("three_bits");
        do_reset(2'b00);
        check_levels("mid_frame_reset");
        for (int s = 0; s < 3; s++) press_step(8'h00);
        check_levels("steps_after_reset");

        // Randomized stretch with occasional resets.
        for (int n = 0; n < 600; n++) begin
            logic [1:0] k;
            k[1] = ($urandom_range(0, 11) == 0);
            k[0] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 79) == 0) do_reset(2'($urandom_range(0, 3)));
            else drive(k, 8'($urandom));
            if (n % 16 == 0) check_levels("random");
        end
        drive(2'b00, 8'h00);
        drive(2'b00, 8'h00);
        check_levels("random_end");

        checks++;
        if (q_lsb.size() != 0 || q_msb.size() != 0) begin
            errors++;
            $display("FAIL missing_valid lsb_pending=%0d msb_pending=%0d want 0 and 0", q_lsb.size(), q_msb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_serial_pattern_tx
